// File: rtl/input_debouncer.sv
// input_debouncer: two independent debounce channels (A, B) for raw, bouncing
// asynchronous inputs. Each channel has a 2-flop synchronizer followed by a
// 4-state FSM with a stability counter. A shared one-cycle pulse flags any
// change of either debounced output.
module input_debouncer #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic a_i,
  input  logic b_i,
  output logic a_o,
  output logic b_o,
  output logic changed_o
);

  localparam int unsigned      CNT_W    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Bit 1 of the encoding is the debounced level, so the output comes straight
  // from a state flop with no decode logic in front of it.
  typedef enum logic [1:0] {
    S_LOW  = 2'b00,
    W_HIGH = 2'b01,
    S_HIGH = 2'b11,
    W_LOW  = 2'b10
  } state_t;

  logic [1:0] raw;
  logic [1:0] level_cur;
  logic [1:0] level_next;
  logic       changed_reg;

  assign raw = {b_i, a_i};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic             meta_reg;
      logic             sync_reg;
      state_t           state_reg;
      state_t           state_next;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;

      // Two-flop synchronizer; only sync_reg is used downstream.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          meta_reg <= 1'b0;
          sync_reg <= 1'b0;
        end else begin
          meta_reg <= raw[gi];
          sync_reg <= meta_reg;
        end
      end

      // Channel state and stability counter registers.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          state_reg <= S_LOW;
          cnt_reg   <= '0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
        end
      end

      // Next-state logic: a new level must be seen STABLE_CYCLES times in a
      // row; any sample of the old level drops back and restarts the count.
      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        unique case (state_reg)
          S_LOW: begin
            if (sync_reg) begin
              if (STABLE_CYCLES == 1) begin
                state_next = S_HIGH;
                cnt_next   = '0;
              end else begin
                state_next = W_HIGH;
                cnt_next   = CNT_ONE;
              end
            end else begin
              cnt_next = '0;
            end
          end
          W_HIGH: begin
            if (!sync_reg) begin
              state_next = S_LOW;
              cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
              state_next = S_HIGH;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end
          S_HIGH: begin
            if (!sync_reg) begin
              if (STABLE_CYCLES == 1) begin
                state_next = S_LOW;
                cnt_next   = '0;
              end else begin
                state_next = W_LOW;
                cnt_next   = CNT_ONE;
              end
            end else begin
              cnt_next = '0;
            end
          end
          W_LOW: begin
            if (sync_reg) begin
              state_next = S_HIGH;
              cnt_next   = '0;
            end else if (cnt_reg == CNT_LAST) begin
              state_next = S_LOW;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CNT_ONE;
            end
          end
          default: begin
            state_next = S_LOW;
            cnt_next   = '0;
          end
        endcase
      end

      assign level_cur[gi]  = state_reg[1];
      assign level_next[gi] = state_next[1];
    end
  endgenerate

  // Change pulse is registered from the next-state levels so it is high in
  // exactly the cycle where a_o/b_o first show their new value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      changed_reg <= 1'b0;
    end else begin
      changed_reg <= |(level_next ^ level_cur);
    end
  end

  assign a_o       = level_cur[0];
  assign b_o       = level_cur[1];
  assign changed_o = changed_reg;

endmodule

// File: tb/tb_input_debouncer.sv
// Testbench for input_debouncer: a STABLE_CYCLES=4 instance and a
// STABLE_CYCLES=1 instance. Expected output transitions (edge number and
// levels) are queued when stimulus is driven and matched against observed
// output changes on the falling clock edge.
module tb_input_debouncer;

  typedef struct {
    int   cyc;
    logic a;
    logic b;
  } exp_t;

  logic clk;
  logic rst_n;
  logic a, b, a1, b1;
  logic a_o, b_o, chg_o;
  logic a1_o, b1_o, chg1_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t q4[$];
  exp_t q1[$];
  logic prev_a4 = 1'b0, prev_b4 = 1'b0, prev_a1 = 1'b0, prev_b1 = 1'b0;

  input_debouncer #(.STABLE_CYCLES(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .a_i(a), .b_i(b),
    .a_o(a_o), .b_o(b_o), .changed_o(chg_o)
  );

  input_debouncer #(.STABLE_CYCLES(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .a_i(a1), .b_i(b1),
    .a_o(a1_o), .b_o(b1_o), .changed_o(chg1_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count rising edges; after edge n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", tag, cyc, got, want);
    end
  endtask

  task automatic push4(input int t, input logic ea, input logic eb);
    exp_t e;
    e.cyc = t; e.a = ea; e.b = eb;
    q4.push_back(e);
  endtask

  task automatic push1(input int t, input logic ea, input logic eb);
    exp_t e;
    e.cyc = t; e.a = ea; e.b = eb;
    q1.push_back(e);
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor for the STABLE_CYCLES=4 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst4_a", int'(a_o), 0);
      chk("rst4_b", int'(b_o), 0);
      chk("rst4_chg", int'(chg_o), 0);
      prev_a4 <= 1'b0;
      prev_b4 <= 1'b0;
    end else begin
      if (q4.size() > 0 && q4[0].cyc < cyc) begin
        chk("late4", cyc, q4[0].cyc);
        q4.delete(0);
      end
      if (a_o !== prev_a4 || b_o !== prev_b4) begin
        if (q4.size() == 0) begin
          chk("unexp_chg4", 1, 0);
        end else begin
          chk("t4", cyc, q4[0].cyc);
          chk("a4", int'(a_o), int'(q4[0].a));
          chk("b4", int'(b_o), int'(q4[0].b));
          $display("dut4 change at edge %0d a_o=%0d b_o=%0d", cyc, a_o, b_o);
          q4.delete(0);
        end
        chk("pulse4", int'(chg_o), 1);
      end else begin
        chk("quiet4", int'(chg_o), 0);
      end
      prev_a4 <= a_o;
      prev_b4 <= b_o;
    end
  end

  // Monitor for the STABLE_CYCLES=1 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst1_a", int'(a1_o), 0);
      chk("rst1_b", int'(b1_o), 0);
      chk("rst1_chg", int'(chg1_o), 0);
      prev_a1 <= 1'b0;
      prev_b1 <= 1'b0;
    end else begin
      if (q1.size() > 0 && q1[0].cyc < cyc) begin
        chk("late1", cyc, q1[0].cyc);
        q1.delete(0);
      end
      if (a1_o !== prev_a1 || b1_o !== prev_b1) begin
        if (q1.size() == 0) begin
          chk("unexp_chg1", 1, 0);
        end else begin
          chk("t1", cyc, q1[0].cyc);
          chk("a1", int'(a1_o), int'(q1[0].a));
          chk("b1", int'(b1_o), int'(q1[0].b));
          $display("dut1 change at edge %0d a_o=%0d b_o=%0d", cyc, a1_o, b1_o);
          q1.delete(0);
        end
        chk("pulse1", int'(chg1_o), 1);
      end else begin
        chk("quiet1", int'(chg1_o), 0);
      end
      prev_a1 <= a1_o;
      prev_b1 <= b1_o;
    end
  end

  // Stimulus. Inputs change on the falling edge, so a level driven when
  // cyc == n is set up before edge n+1 and, with STABLE_CYCLES = S, appears
  // on the output after edge n+2+S.
  initial begin
    a = 1'b0; b = 1'b0; a1 = 1'b0; b1 = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    wait_n(3);
    rst_n = 1'b1;
    wait_n(3);

    // Clean rise and fall on A; B must stay low.
    a = 1'b1; push4(cyc + 6, 1'b1, 1'b0); wait_n(10);
    a = 1'b0; push4(cyc + 6, 1'b0, 1'b0); wait_n(10);

    // Glitch of S-1 samples is rejected.
    a = 1'b1; wait_n(3);
    a = 1'b0; wait_n(10);

    // Glitch, one low sample, then a hold: count restarts from the hold.
    a = 1'b1; wait_n(3);
    a = 1'b0; wait_n(1);
    a = 1'b1; push4(cyc + 6, 1'b1, 1'b0); wait_n(10);
    a = 1'b0; push4(cyc + 6, 1'b0, 1'b0); wait_n(10);

    // Exactly S high samples is enough.
    a = 1'b1; push4(cyc + 6, 1'b1, 1'b0); wait_n(4);
    a = 1'b0; push4(cyc + 6, 1'b0, 1'b0); wait_n(10);

    // Glitch of S-1 samples on B is rejected.
    b = 1'b1; wait_n(3);
    b = 1'b0; wait_n(10);

    // Simultaneous rise on both channels gives one combined change.
    a = 1'b1; b = 1'b1; push4(cyc + 6, 1'b1, 1'b1); wait_n(10);
    b = 1'b0; push4(cyc + 6, 1'b1, 1'b0); wait_n(10);
    a = 1'b0; push4(cyc + 6, 1'b0, 1'b0); wait_n(10);

    // Bounce while low: toggling every 2 cycles never changes the output.
    for (int i = 0; i < 10; i++) begin
      a = (i % 2 == 0) ? 1'b1 : 1'b0;
      wait_n(2);
    end
    a = 1'b1; push4(cyc + 6, 1'b1, 1'b0); wait_n(12);

    // Bounce while high: output holds 1 until a stable low.
    for (int i = 0; i < 10; i++) begin
      a = (i % 2 == 0) ? 1'b0 : 1'b1;
      wait_n(2);
    end
    a = 1'b0; push4(cyc + 6, 1'b0, 1'b0); wait_n(10);

    // Reset while waiting (W_HIGH, cnt=2 after 4 edges).
    a = 1'b1; wait_n(4);
    #2 rst_n = 1'b0;
    #1 chk("async_w_a", int'(a_o), 0);
    chk("async_w_chg", int'(chg_o), 0);
    wait_n(2);
    rst_n = 1'b1; push4(cyc + 6, 1'b1, 1'b0); wait_n(10);

    // Reset while high: output drops at once, no change pulse.
    #2 rst_n = 1'b0;
    #1 chk("async_h_a", int'(a_o), 0);
    chk("async_h_chg", int'(chg_o), 0);
    wait_n(2);
    rst_n = 1'b1; push4(cyc + 6, 1'b1, 1'b0); wait_n(10);
    a = 1'b0; push4(cyc + 6, 1'b0, 1'b0); wait_n(10);

    // STABLE_CYCLES=1: output after edge k+2; single-cycle pulses propagate.
    a1 = 1'b1; push1(cyc + 3, 1'b1, 1'b0); wait_n(5);
    a1 = 1'b0; push1(cyc + 3, 1'b0, 1'b0); wait_n(5);
    a1 = 1'b1; push1(cyc + 3, 1'b1, 1'b0); wait_n(1);
    a1 = 1'b0; push1(cyc + 3, 1'b0, 1'b0); wait_n(5);
    a1 = 1'b1; b1 = 1'b1; push1(cyc + 3, 1'b1, 1'b1); wait_n(1);
    a1 = 1'b0; b1 = 1'b0; push1(cyc + 3, 1'b0, 1'b0); wait_n(6);

    chk("sb4_empty", q4.size(), 0);
    chk("sb1_empty", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/input_debouncer.md
INPUT_DEBOUNCER -- requirements
Module: input_debouncer

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4: consecutive synchronized samples required before an output changes; legal range 1..255.
REQ-002 SHALL have port clk_i, input, 1 bit: the single clock for the block.
REQ-003 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port a_i, input, 1 bit: raw, asynchronous, possibly bouncing channel A.
REQ-005 SHALL have port b_i, input, 1 bit: raw, asynchronous, possibly bouncing channel B.
REQ-006 SHALL have port a_o, output, 1 bit: registered, debounced channel A, intended to drive the downstream 2-input AND stage.
REQ-007 SHALL have port b_o, output, 1 bit: registered, debounced channel B, intended to drive the downstream 2-input AND stage.
REQ-008 SHALL have port changed_o, output, 1 bit: one-cycle pulse marking an update of a_o and/or b_o.

Function
REQ-009 SHALL implement two independent, identical channels (A, B); channels share only clk_i, rst_ni and changed_o.
REQ-010 SHALL pass each raw input through a 2-flop synchronizer; only the second-flop output (sync) feeds the channel FSM.
REQ-011 SHALL give each channel an FSM with states S_LOW, W_HIGH, S_HIGH, W_LOW and a counter cnt of width clog2(STABLE_CYCLES+1).
REQ-012 S_LOW: sync=0 -> stay, cnt=0; sync=1 and STABLE_CYCLES=1 -> S_HIGH; sync=1 otherwise -> W_HIGH, cnt=1.
REQ-013 W_HIGH: sync=0 -> S_LOW, cnt=0 (glitch rejected); sync=1 and cnt=STABLE_CYCLES-1 -> S_HIGH, cnt=0; sync=1 otherwise -> cnt+1.
REQ-014 S_HIGH and W_LOW SHALL mirror S_LOW and W_HIGH with the polarity inverted.
REQ-015 Channel output SHALL be 1 in S_HIGH and W_LOW and 0 in S_LOW and W_HIGH, driven directly from the state register with no combinational path from a_i/b_i.
REQ-016 Latency: a raw level set up before edge k and held SHALL appear on the output after edge k+1+STABLE_CYCLES.
REQ-017 Any run of the new level shorter than STABLE_CYCLES synchronized samples SHALL leave the output unchanged, with cnt restarting from 0.
REQ-018 cnt SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-019 changed_o SHALL be 1 in exactly the cycle in which a_o or b_o holds a value different from the previous cycle, and 0 otherwise.
REQ-020 If both channels update on the same edge, changed_o SHALL produce a single one-cycle pulse.
REQ-021 A continuously toggling input with period shorter than STABLE_CYCLES SHALL never change the output.

Reset
REQ-022 On rst_ni=0, independent of clk_i, the following SHALL clear: synchronizer flops to 0, state to S_LOW, cnt to 0, a_o/b_o/changed_o to 0.
REQ-023 Reset asserted mid-operation (any state or cnt value) SHALL force all outputs to 0 immediately, with no changed_o pulse generated by the reset itself.
REQ-024 After rst_ni releases with a raw input held at 1, the output SHALL rise 1+STABLE_CYCLES edges after the first sampling edge, and changed_o SHALL pulse once.

Verification
REQ-025 Clean edge (STABLE_CYCLES=4): a_i 0->1 before edge 10, then held -> a_o=1 after edge 15; changed_o=1 for exactly that cycle; b_o stays 0.
REQ-026 Glitch reject: a_i high for 3 cycles, then low -> a_o stays 0 and changed_o never asserts; a following hold of 4+ cycles -> a_o rises per REQ-016.
REQ-027 Simultaneous: a_i and b_i both rise before the same edge -> a_o and b_o rise on the same edge, with a single changed_o pulse.
REQ-028 Bounce: a_i toggles every 2 cycles for 20 cycles, then holds 1 -> a_o rises exactly 5 edges after the last toggle is sampled, with no earlier transition.
REQ-029 Reset mid-wait and mid-high: assert rst_ni while W_HIGH with cnt=2, and again while a_o=1 -> outputs 0 asynchronously; after release with input held 1 -> recovery per REQ-024.
REQ-030 STABLE_CYCLES=1: a_i rise before edge k -> a_o=1 after edge k+2; a 1-cycle pulse on a_i SHALL propagate.
